uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receive half of the UART pair: deserialises 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity) from the i_rx pin.
- Received bytes are buffered in a small FIFO for the register/bus side to drain.
- Shares c_baud_cyc semantics with the transmitter: one bit period = c_baud_cyc+1 clock cycles.
- Reports framing errors and FIFO overruns as single-cycle pulses.

Parameters:
- FifoDepth, 4, number of received-byte entries in the internal fifo instance.
- BaudCycBits, 16, width of c_baud_cyc and of the cycle counter.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- c_baud_cyc  input  BaudCycBits  bit period minus one, in cycles. Static while o_busy; minimum legal value 3.
- i_rx  input  1  serial line, asynchronous to i_clk, idles high.
- o_busy  output  1  high whenever the FSM is not IDLE.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: valid byte dropped because the FIFO was full.
- o_fifo_empty  output  1  FIFO holds no bytes.
- i_fifo_read  input  1  pop request. Ignored when empty.
- o_fifo_rdata  output  8  head-of-FIFO byte, show-ahead. Valid while !o_fifo_empty.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_rst_n, asynchronous and active-low.
- Reset values: o_busy=0, o_frame_err=0, o_overrun=0, o_fifo_empty=1. Synchroniser flops=1, FSM=IDLE, counters=0, shift register=0.
- Synchroniser: i_rx passes through 2 flops to give rx_s. All FSM decisions use rx_s only.
- Tick: tick = (state != IDLE) && (cyc_cnt == 0). When not ticking and not IDLE, cyc_cnt decrements.
- IDLE:
  - rx_s==0 -> START, cyc_cnt = c_baud_cyc>>1 (half-bit, so samples land mid-bit).
- START:
  - On tick with rx_s==0 -> DATA, cyc_cnt=c_baud_cyc, bit_cnt=0.
  - On tick with rx_s==1 -> IDLE. Glitch rejected; no error pulse, no write.
- DATA:
  - On tick: data = {rx_s, data[7:1]}, cyc_cnt=c_baud_cyc, bit_cnt+1 (3-bit).
  - On tick with bit_cnt==7 -> STOP.
- STOP, on tick (mid stop bit):
  - rx_s==1, FIFO not full: write data, -> IDLE.
  - rx_s==1, FIFO full: drop byte, pulse o_overrun, -> IDLE.
  - rx_s==0: discard byte, pulse o_frame_err, -> BREAK.
- BREAK:
  - Stays until rx_s==1, then -> IDLE.
  - Prevents a held-low line (break) from producing repeated frames.
- Back-to-back frames: returning to IDLE mid stop bit allows detection of the next start edge at the earliest point.
- FIFO:
  - Uses the codebase fifo module (Width 8, Depth FifoDepth).
  - Write is gated by !full in the same cycle. A simultaneous pop does not free a slot for that write.
  - Read and write in the same cycle on a non-empty, non-full FIFO are both honoured.
- Latency: the FIFO write occurs (c_baud_cyc>>1) + 9*(c_baud_cyc+1) + 3 cycles after the falling edge on i_rx (±1 for sampling phase). o_fifo_empty falls the next cycle.
- Reset mid-frame: the partial byte is lost and the FIFO is emptied. After release, the block waits for a falling edge on a high line.
- o_frame_err and o_overrun are never asserted together and last exactly one cycle each.

Test Plan:
- Clean byte: c_baud_cyc=15, drive 0xA5 (16 cycles/bit) -> exactly one write. o_fifo_rdata=0xA5, o_fifo_empty=0 within 4 cycles of the computed latency, no error pulses, o_busy low afterwards.
- Back-to-back: c_baud_cyc=15, frames 0x00, 0xFF, 0x3C with no idle gap -> FIFO pops in order 0x00, 0xFF, 0x3C.
- Glitch and framing: a 4-cycle low pulse on i_rx -> o_busy rises then falls, no write. Frame 0x55 with stop bit low -> one o_frame_err pulse, no write. Line held low 100 more cycles -> o_busy stays high (BREAK), no further pulses; release -> IDLE.
- Overrun: FifoDepth=4, send 5 bytes 0x01..0x05 without reading -> o_overrun pulses once on byte 5, FIFO holds 0x01..0x04. Pop all -> o_fifo_empty=1.
- Simultaneous read/write: FIFO full, i_fifo_read asserted on the write cycle -> byte dropped with o_overrun. FIFO with 2 entries, read and write in the same cycle -> count stays 2, order preserved.
- Reset mid-frame: assert i_rst_n=0 during data bit 4 of 0x96 -> all outputs at reset values immediately. After release, the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchroniser, break handling
// and a show-ahead byte FIFO; framing errors and overruns are one-cycle pulses.
module fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic [Width-1:0] wdata,
    input  logic             read,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = Depth > 1 ? $clog2(Depth) : 1;
    localparam logic [AW:0] FullCount = (AW + 1)'(Depth);
    localparam logic [AW-1:0] LastPtr = AW'(Depth - 1);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // full/empty come from registered state, so a same-cycle pop never frees a slot for the write
    assign full  = count == FullCount;
    assign empty = count == '0;
    assign do_wr = write && !full;
    assign do_rd = read && !empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr == LastPtr ? '0 : wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr == LastPtr ? '0 : rd_ptr + AW'(1);
            if (do_wr && !do_rd) count <= count + (AW + 1)'(1);
            else if (!do_wr && do_rd) count <= count - (AW + 1)'(1);
        end
    end
endmodule

module uart_rx #(
    parameter int FifoDepth   = 4,
    parameter int BaudCycBits = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [BaudCycBits-1:0] c_baud_cyc,
    input  logic                   i_rx,
    output logic                   o_busy,
    output logic                   o_frame_err,
    output logic                   o_overrun,
    output logic                   o_fifo_empty,
    input  logic                   i_fifo_read,
    output logic [7:0]             o_fifo_rdata
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [1:0]             sync;
    logic                   rx_s;
    logic [BaudCycBits-1:0] cyc_cnt;
    logic [BaudCycBits-1:0] cyc_nx;
    logic [2:0]             bit_cnt;
    logic [2:0]             bit_nx;
    logic [7:0]             data;
    logic [7:0]             data_nx;
    logic                   tick;
    logic                   wr;
    logic                   fifo_full;
    logic                   frame_err_nx;
    logic                   overrun_nx;

    assign rx_s   = sync[1];
    assign o_busy = state != IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync        <= 2'b11;
            state       <= IDLE;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            data        <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            sync        <= {sync[0], i_rx};
            state       <= state_nx;
            cyc_cnt     <= cyc_nx;
            bit_cnt     <= bit_nx;
            data        <= data_nx;
            o_frame_err <= frame_err_nx;
            o_overrun   <= overrun_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cyc_nx       = cyc_cnt;
        bit_nx       = bit_cnt;
        data_nx      = data;
        wr           = 1'b0;
        frame_err_nx = 1'b0;
        overrun_nx   = 1'b0;
        tick         = state != IDLE && cyc_cnt == '0;
        if (state != IDLE && !tick) cyc_nx = cyc_cnt - BaudCycBits'(1);
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    cyc_nx   = c_baud_cyc >> 1;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = rx_s ? IDLE : DATA;
                    cyc_nx   = c_baud_cyc;
                    bit_nx   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    data_nx = {rx_s, data[7:1]};
                    cyc_nx  = c_baud_cyc;
                    bit_nx  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                // leaving mid stop bit lets the next start edge be seen as early as possible
                if (tick) begin
                    wr           = rx_s && !fifo_full;
                    overrun_nx   = rx_s && fifo_full;
                    frame_err_nx = !rx_s;
                    state_nx     = rx_s ? IDLE : BRK;
                end
            end
            BRK: begin
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    fifo #(
        .Width(8),
        .Depth(FifoDepth)
    ) u_fifo (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .write(wr),
        .wdata(data),
        .read (i_fifo_read),
        .rdata(o_fifo_rdata),
        .full (fifo_full),
        .empty(o_fifo_empty)
    );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: vector table, directed corner sequences and randomized frames
// checked against a queue-based model of the receiver FIFO and error pulses.
module tb_uart_rx;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_rx = 1'b1;
    logic        i_fifo_read = 1'b0;
    logic [15:0] c_baud_cyc = 16'd15;
    logic        o_busy;
    logic        o_frame_err;
    logic        o_overrun;
    logic        o_fifo_empty;
    logic [7:0]  o_fifo_rdata;

    int   total = 0;
    int   bad = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_fe;
        logic       exp_wr;
    } vec_t;
    vec_t vecs[6];

    uart_rx #(
        .FifoDepth(4),
        .BaudCycBits(16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .c_baud_cyc  (c_baud_cyc),
        .i_rx        (i_rx),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_fifo_empty(o_fifo_empty),
        .i_fifo_read (i_fifo_read),
        .o_fifo_rdata(o_fifo_rdata)
    );

    always #5 i_clk = ~i_clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endfunction

    always @(negedge i_clk) begin
        if (o_frame_err) fe_cnt++;
        if (o_overrun) ov_cnt++;
        if (o_frame_err || o_overrun) begin
            chk("pulse_exclusive", 32'(o_frame_err && o_overrun), 0);
            chk("pulse_one_cycle", 32'((o_frame_err && fe_prev) || (o_overrun && ov_prev)), 0);
        end
        fe_prev = o_frame_err;
        ov_prev = o_overrun;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rel);
        int bp;
        bp = int'(c_baud_cyc) + 1;
        i_rx = 1'b0;
        cyc(bp);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            cyc(bp);
        end
        i_rx = stop;
        cyc(bp);
        if (rel) i_rx = 1'b1;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (o_busy && n < lim) begin
            cyc(1);
            n++;
        end
        chk("idle_timeout", 32'(o_busy), 0);
    endtask

    task automatic pop_check(input string nm, input logic [7:0] want);
        chk({nm, "_empty"}, 32'(o_fifo_empty), 0);
        chk({nm, "_data"}, 32'(o_fifo_rdata), 32'(want));
        i_fifo_read = 1'b1;
        cyc(1);
        i_fifo_read = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        cyc(2);
        i_rst_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        int fe0;
        int ov0;
        int n;
        int seen;
        int exp_fe;
        int exp_ov;
        logic [7:0] q[$];
        logic [7:0] b;
        logic stop;

        vecs[0] = '{8'h00, 1'b1, 0, 1'b1};
        vecs[1] = '{8'hFF, 1'b1, 0, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 0, 1'b1};
        vecs[5] = '{8'hC3, 1'b0, 1, 1'b0};

        cyc(2);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_frame_err", 32'(o_frame_err), 0);
        chk("rst_overrun", 32'(o_overrun), 0);
        chk("rst_empty", 32'(o_fifo_empty), 1);
        i_rst_n = 1'b1;
        cyc(3);

        // clean byte with latency measurement: 7 + 9*16 + 3 = 154, empty falls one later
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                while (o_fifo_empty && n < 300) begin
                    cyc(1);
                    n++;
                end
            end
        join
        chk("latency", (n >= 151 && n <= 159) ? 155 : n, 155);
        wait_idle(50);
        cyc(2);
        chk("clean_fe", fe_cnt - fe0, 0);
        chk("clean_ov", ov_cnt - ov0, 0);
        chk("clean_busy", 32'(o_busy), 0);
        pop_check("clean", 8'hA5);
        chk("clean_empty_after", 32'(o_fifo_empty), 1);

        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send_frame(vecs[i].data, vecs[i].stop, 1'b1);
            wait_idle(50);
            cyc(2);
            chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
            chk($sformatf("vec%0d_ov", i), ov_cnt - ov0, 0);
            if (vecs[i].exp_wr) pop_check($sformatf("vec%0d", i), vecs[i].data);
            chk($sformatf("vec%0d_empty", i), 32'(o_fifo_empty), 1);
        end

        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_idle(50);
        cyc(2);
        pop_check("b2b0", 8'h00);
        pop_check("b2b1", 8'hFF);
        pop_check("b2b2", 8'h3C);
        chk("b2b_empty", 32'(o_fifo_empty), 1);

        // short low glitch: busy rises, start is rejected
        fe0 = fe_cnt;
        i_rx = 1'b0;
        cyc(4);
        i_rx = 1'b1;
        seen = 0;
        repeat (10) begin
            cyc(1);
            if (o_busy) seen = 1;
        end
        chk("glitch_busy", seen, 1);
        wait_idle(40);
        chk("glitch_fe", fe_cnt - fe0, 0);
        chk("glitch_empty", 32'(o_fifo_empty), 1);

        // framing error then break held low
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        cyc(100);
        chk("break_busy", 32'(o_busy), 1);
        chk("break_fe", fe_cnt - fe0, 1);
        i_rx = 1'b1;
        wait_idle(20);
        cyc(2);
        chk("break_fe_after", fe_cnt - fe0, 1);
        chk("break_empty", 32'(o_fifo_empty), 1);

        // overrun on the fifth byte
        ov0 = ov_cnt;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 1'b1);
            wait_idle(50);
            cyc(2);
            chk($sformatf("ovr_byte%0d", k), ov_cnt - ov0, (k == 5) ? 1 : 0);
        end
        for (int k = 1; k <= 4; k++) pop_check($sformatf("ovr_pop%0d", k), 8'(k));
        chk("ovr_empty", 32'(o_fifo_empty), 1);

        // pop on the write cycle of a full fifo does not make room
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b1);
        wait_idle(50);
        ov0 = ov_cnt;
        fork
            send_frame(8'h77, 1'b1, 1'b1);
            begin
                cyc(154);
                i_fifo_read = 1'b1;
                cyc(1);
                i_fifo_read = 1'b0;
            end
        join
        wait_idle(50);
        cyc(2);
        chk("simul_full_ov", ov_cnt - ov0, 1);
        pop_check("simul_a", 8'h02);
        ov0 = ov_cnt;
        fork
            send_frame(8'h88, 1'b1, 1'b1);
            begin
                cyc(154);
                i_fifo_read = 1'b1;
                cyc(1);
                i_fifo_read = 1'b0;
            end
        join
        wait_idle(50);
        cyc(2);
        chk("simul_rw_ov", ov_cnt - ov0, 0);
        pop_check("simul_b", 8'h04);
        pop_check("simul_c", 8'h88);
        chk("simul_empty", 32'(o_fifo_empty), 1);

        // reset during data bit 4
        send_frame(8'h11, 1'b1, 1'b1);
        wait_idle(50);
        fork
            send_frame(8'h96, 1'b1, 1'b1);
            begin
                cyc(16 * 5 + 8);
                i_rst_n = 1'b0;
                #1;
                chk("mid_rst_busy", 32'(o_busy), 0);
                chk("mid_rst_fe", 32'(o_frame_err), 0);
                chk("mid_rst_ov", 32'(o_overrun), 0);
                chk("mid_rst_empty", 32'(o_fifo_empty), 1);
            end
        join
        i_rx = 1'b1;
        cyc(2);
        i_rst_n = 1'b1;
        cyc(3);
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_idle(50);
        cyc(2);
        pop_check("after_rst", 8'h5A);
        chk("after_rst_empty", 32'(o_fifo_empty), 1);

        // randomized frames against the queue model
        do_reset();
        exp_fe = 0;
        exp_ov = 0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        for (int it = 0; it < 40; it++) begin
            c_baud_cyc = 16'($urandom_range(3, 24));
            b = 8'($urandom);
            stop = $urandom_range(0, 4) != 0;
            send_frame(b, stop, 1'b1);
            wait_idle(60);
            cyc(2);
            if (!stop) exp_fe++;
            else if (q.size() < 4) q.push_back(b);
            else exp_ov++;
            chk($sformatf("rnd%0d_fe", it), fe_cnt - fe0, exp_fe);
            chk($sformatf("rnd%0d_ov", it), ov_cnt - ov0, exp_ov);
            chk($sformatf("rnd%0d_empty", it), 32'(o_fifo_empty), 32'(q.size() == 0));
            if ($urandom_range(0, 2) == 0 && q.size() > 0) pop_check($sformatf("rnd%0d_pop", it), q.pop_front());
            cyc($urandom_range(0, 5));
        end
        while (q.size() > 0) pop_check("rnd_drain", q.pop_front());
        chk("rnd_final_empty", 32'(o_fifo_empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
